// File: rtl/serial_frame_pkg.sv
// Shared constants and FSM encoding for the framed serial multiplexer.
package serial_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h7E;
    localparam logic [7:0] ESC_BYTE  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_CHAN    = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_ESC     = 3'd4
    } state_e;

    function automatic logic needs_esc(input logic [7:0] b);
        return (b == SYNC_BYTE) || (b == ESC_BYTE);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant_idx,
    output logic          grant_valid
);

    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        // Walk offsets from farthest to nearest so the nearest request wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                grant_idx   = PW'((int'(ptr) + i) % N);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_frame_mux.sv
// N-channel word arbiter emitting HDLC-style frames: 0x7E, channel id, escaped payload MSB first.
module serial_frame_mux
    import serial_frame_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int WORD_BYTES = 2,
    parameter int PRIO0      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_CH*WORD_BYTES*8-1:0] in_data,
    input  logic [N_CH-1:0]              in_stb,
    output logic [N_CH-1:0]              in_ack,
    output logic [7:0]                   out_data,
    output logic                         out_stb,
    input  logic                         out_ack,
    output logic                         busy,
    output logic [15:0]                  frame_count
);

    localparam int WW = WORD_BYTES * 8;
    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    state_e          state_q, state_d;
    logic [WW-1:0]   word_q, word_d;
    logic [3:0]      chan_q, chan_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_stb_q, out_stb_d;
    logic            busy_q, busy_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic [N_CH-1:0] in_ack_c;

    logic [PW-1:0] arb_idx, gnt;
    logic          arb_valid, prio_hit, advance;
    logic [7:0]    cur_byte, nxt_byte;

    function automatic logic [7:0] byte_of(input logic [WW-1:0] w, input logic [IW-1:0] i);
        return w[int'(i)*8 +: 8];
    endfunction

    rr_arbiter #(.N(N_CH), .PW(PW)) u_arb (
        .req         (in_stb),
        .ptr         (rr_ptr_q),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign prio_hit = (PRIO0 != 0) && in_stb[0];
    assign gnt      = prio_hit ? '0 : arb_idx;
    assign cur_byte = byte_of(word_q, idx_q);

    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        chan_d        = chan_q;
        idx_d         = idx_q;
        rr_ptr_d      = rr_ptr_q;
        out_data_d    = out_data_q;
        out_stb_d     = out_stb_q;
        busy_d        = busy_q;
        frame_count_d = frame_count_q;
        in_ack_c      = '0;
        advance       = 1'b0;
        nxt_byte      = '0;

        case (state_q)
            ST_IDLE: if (arb_valid) begin
                in_ack_c[gnt] = 1'b1;
                word_d        = in_data[int'(gnt)*WW +: WW];
                chan_d        = 4'(gnt);
                if (!prio_hit)
                    rr_ptr_d = (gnt == PW'(N_CH - 1)) ? '0 : PW'(gnt + 1'b1);
                state_d       = ST_SYNC;
                out_stb_d     = 1'b1;
                out_data_d    = SYNC_BYTE;
                busy_d        = 1'b1;
            end
            ST_SYNC: if (out_ack) begin
                state_d    = ST_CHAN;
                out_data_d = {4'h0, chan_q};
            end
            ST_CHAN: if (out_ack) begin
                idx_d      = IW'(WORD_BYTES - 1);
                nxt_byte   = byte_of(word_q, IW'(WORD_BYTES - 1));
                state_d    = ST_PAYLOAD;
                out_data_d = needs_esc(nxt_byte) ? ESC_BYTE : nxt_byte;
            end
            ST_PAYLOAD: if (out_ack) begin
                if (needs_esc(cur_byte)) begin
                    state_d    = ST_ESC;
                    out_data_d = cur_byte ^ ESC_XOR;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_ESC: if (out_ack) advance = 1'b1;
            default: state_d = ST_IDLE;
        endcase

        // Current payload byte fully sent: close the frame or step to the next lower byte.
        if (advance) begin
            if (idx_q == '0) begin
                state_d       = ST_IDLE;
                out_stb_d     = 1'b0;
                busy_d        = 1'b0;
                frame_count_d = frame_count_q + 16'd1;
            end else begin
                idx_d      = IW'(idx_q - 1'b1);
                nxt_byte   = byte_of(word_q, IW'(idx_q - 1'b1));
                state_d    = ST_PAYLOAD;
                out_data_d = needs_esc(nxt_byte) ? ESC_BYTE : nxt_byte;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            word_q        <= '0;
            chan_q        <= '0;
            idx_q         <= '0;
            rr_ptr_q      <= '0;
            out_data_q    <= '0;
            out_stb_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            chan_q        <= chan_d;
            idx_q         <= idx_d;
            rr_ptr_q      <= rr_ptr_d;
            out_data_q    <= out_data_d;
            out_stb_q     <= out_stb_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
        end
    end

    // The grant is decoded from live in_stb, so it must be masked while reset is held.
    assign in_ack      = rst ? '0 : in_ack_c;
    assign out_data    = out_data_q;
    assign out_stb     = out_stb_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_serial_frame_mux.sv
// Directed bench: one round-robin and one channel-0-priority instance on shared stimulus.
module tb_serial_frame_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic [3:0]  in_stb;
    logic        out_ack;

    logic [3:0]  rr_in_ack, pr_in_ack;
    logic [7:0]  rr_out_data, pr_out_data;
    logic        rr_out_stb, pr_out_stb;
    logic        rr_busy, pr_busy;
    logic [15:0] rr_fc, pr_fc;

    bit          sel;
    logic [3:0]  obs_in_ack;
    logic [7:0]  obs_out_data;
    logic        obs_out_stb, obs_busy;
    logic [15:0] obs_fc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_frame_mux #(.N_CH(4), .WORD_BYTES(2), .PRIO0(0)) u_rr (
        .clk(clk), .rst(rst), .in_data(in_data), .in_stb(in_stb), .in_ack(rr_in_ack),
        .out_data(rr_out_data), .out_stb(rr_out_stb), .out_ack(out_ack),
        .busy(rr_busy), .frame_count(rr_fc)
    );

    serial_frame_mux #(.N_CH(4), .WORD_BYTES(2), .PRIO0(1)) u_pr (
        .clk(clk), .rst(rst), .in_data(in_data), .in_stb(in_stb), .in_ack(pr_in_ack),
        .out_data(pr_out_data), .out_stb(pr_out_stb), .out_ack(out_ack),
        .busy(pr_busy), .frame_count(pr_fc)
    );

    assign obs_in_ack   = sel ? pr_in_ack   : rr_in_ack;
    assign obs_out_data = sel ? pr_out_data : rr_out_data;
    assign obs_out_stb  = sel ? pr_out_stb  : rr_out_stb;
    assign obs_busy     = sel ? pr_busy     : rr_busy;
    assign obs_fc       = sel ? pr_fc       : rr_fc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int ch, input logic [15:0] w);
        in_data[ch*16 +: 16] = w;
        in_stb[ch]           = 1'b1;
    endtask

    // Called at a falling edge; waits for the grant and retires the source word.
    task automatic wait_grant(input string tag, input int ch, input bit keep);
        bit got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            #1;
            if (obs_in_ack != 4'b0) begin
                got = 1'b1;
                chk({tag, " grant"}, 32'(obs_in_ack), 32'd1 << ch);
                @(posedge clk); @(negedge clk);
                #1 chk({tag, " ack_pulse"}, 32'(obs_in_ack), 32'd0);
                if (!keep) in_stb[ch] = 1'b0;
            end else begin
                @(posedge clk); @(negedge clk);
            end
        end
        if (!got) chk({tag, " grant_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic get_byte(input bit rnd, input string tag, output logic [7:0] b);
        bit         held = 1'b0;
        bit         done = 1'b0;
        logic [7:0] prev = 8'h00;
        b = 8'h00;
        for (int n = 0; n < 64 && !done; n++) begin
            out_ack = rnd ? (($urandom % 3) != 0) : 1'b1;
            #1;
            if (held) chk({tag, " stall_hold"}, 32'({obs_out_stb, obs_out_data}), 32'({1'b1, prev}));
            if (obs_out_stb) begin
                if (out_ack) begin
                    b    = obs_out_data;
                    done = 1'b1;
                end else begin
                    held = 1'b1;
                    prev = obs_out_data;
                end
            end else begin
                held = 1'b0;
            end
            @(posedge clk); @(negedge clk);
        end
        out_ack = 1'b1;
        if (!done) chk({tag, " byte_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_frame(input string tag, input int ch, input bit keep, input bit rnd,
                            input logic [47:0] exp, input int n);
        logic [7:0] b;
        wait_grant(tag, ch, keep);
        #1 chk({tag, " busy"}, 32'(obs_busy), 32'd1);
        for (int k = 0; k < n; k++) begin
            get_byte(rnd, tag, b);
            chk($sformatf("%s byte%0d", tag, k), 32'(b), 32'(exp[(n-1-k)*8 +: 8]));
        end
        #1 chk({tag, " stb_drop"}, 32'(obs_out_stb), 32'd0);
        chk({tag, " idle"}, 32'(obs_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        in_data = '0;
        in_stb  = 4'b1111;
        out_ack = 1'b1;
        sel     = 1'b0;

        // Reset state, with every strobe high to show the grant is masked.
        @(negedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("reset in_ack", 32'(obs_in_ack), 32'd0);
            chk("reset out_stb", 32'(obs_out_stb), 32'd0);
            chk("reset busy", 32'(obs_busy), 32'd0);
            chk("reset fc", 32'(obs_fc), 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        in_stb = 4'b0;
        rst    = 1'b0;

        // Single word on channel 2.
        put(2, 16'h1234);
        do_frame("single", 2, 1'b0, 1'b0, 48'h0000_7E02_1234, 4);
        chk("single fc", 32'(obs_fc), 32'd1);

        // Reset right after the sync byte goes out.
        put(2, 16'hABCD);
        wait_grant("midrst", 2, 1'b0);
        begin
            logic [7:0] b;
            get_byte(1'b0, "midrst", b);
            chk("midrst sync", 32'(b), 32'h7E);
        end
        rst = 1'b1;
        put(2, 16'hABCD);
        #1;
        chk("midrst out_stb", 32'(obs_out_stb), 32'd0);
        chk("midrst busy", 32'(obs_busy), 32'd0);
        chk("midrst fc", 32'(obs_fc), 32'd0);
        chk("midrst in_ack", 32'(obs_in_ack), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_frame("resync", 2, 1'b0, 1'b0, 48'h0000_7E02_ABCD, 4);
        chk("resync fc", 32'(obs_fc), 32'd1);

        // Both payload bytes need escaping, with a stalling sink.
        put(1, 16'h7E7D);
        do_frame("escape", 1, 1'b0, 1'b1, 48'h7E01_7D5E_7D5D, 6);
        chk("escape fc", 32'(obs_fc), 32'd2);

        // Round-robin from a fresh pointer: 0, 1, 3; then {0,3} shows the pointer wrapped to 0.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        put(0, 16'h0011); put(1, 16'h2233); put(3, 16'h4455);
        do_frame("rr ch0", 0, 1'b0, 1'b0, 48'h0000_7E00_0011, 4);
        do_frame("rr ch1", 1, 1'b0, 1'b0, 48'h0000_7E01_2233, 4);
        do_frame("rr ch3", 3, 1'b0, 1'b0, 48'h0000_7E03_4455, 4);
        put(3, 16'h8899); put(0, 16'h6677);
        do_frame("rrwrap ch0", 0, 1'b0, 1'b0, 48'h0000_7E00_6677, 4);
        do_frame("rrwrap ch3", 3, 1'b0, 1'b0, 48'h0000_7E03_8899, 4);
        chk("rr fc", 32'(obs_fc), 32'd5);

        // Channel 0 priority starves channel 3 until channel 0 goes quiet.
        sel = 1'b1;
        put(0, 16'h0102); put(3, 16'h0304);
        for (int f = 0; f < 3; f++)
            do_frame($sformatf("prio ch0 #%0d", f), 0, 1'b1, 1'b0, 48'h0000_7E00_0102, 4);
        in_stb[0] = 1'b0;
        do_frame("prio ch3", 3, 1'b0, 1'b0, 48'h0000_7E03_0304, 4);
        in_stb = 4'b0;
        repeat (20) @(negedge clk);

        // Frame counter wraps from 0xFFFF to 0.
        force u_pr.frame_count_q = 16'hFFFF;
        @(negedge clk);
        release u_pr.frame_count_q;
        @(negedge clk);
        put(2, 16'h5A5A);
        do_frame("wrap", 2, 1'b0, 1'b0, 48'h0000_7E02_5A5A, 4);
        chk("wrap fc", 32'(obs_fc), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
